memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage. Consumes the EX-stage outputs (control, destination register, ALU result, store data, PC+4) and performs load/store accesses to an external data memory over a variable-latency request/ready handshake. It stalls the upstream pipeline while an access is outstanding and drives the MEM/WB register (`ResultW`, `RD_W`, `RegWrtW`). `ResultW` also feeds the EX forwarding muxes.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles an access waits for `dmem_ready` before it is aborted. Range 2..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `RegWrtMem` in 1: instruction writes the register file.
- `MemWrtMem` in 1: store.
- `ResultSrcMem` in 1: load; result comes from memory, not the ALU.
- `RD_Mem` in 5: destination register.
- `PCplus4Mem` in 32: PC+4, passed through to WB.
- `WriteDataMem` in 32: store data.
- `ALU_ResultMem` in 32: ALU result, or effective address for a memory op.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: write enable, qualified by `dmem_req`.
- `dmem_addr` out 32: word address.
- `dmem_wdata` out 32: store data.
- `dmem_ready` in 1: access complete this cycle; `dmem_rdata` is valid.
- `dmem_rdata` in 32: load data.
- `StallMem` out 1: hold IF/ID/EX/MEM inputs stable.
- `RegWrtW` out 1: registered write-back enable.
- `RD_W` out 5: registered destination register.
- `ResultW` out 32: registered write-back data.
- `PCplus4W` out 32: registered PC+4.
- `MemErr` out 1: one-cycle registered pulse on timeout.

## Operation
- Memory op (`memop`) = `MemWrtMem | ResultSrcMem`. Non-memory ops never touch the `dmem_*` pins.
- FSM states:
  - IDLE:
    - No `memop`: capture the ALU path into WB; `StallMem=0`.
    - `memop`: `dmem_req=1`, `dmem_we=MemWrtMem`, `dmem_addr=ALU_ResultMem`, `dmem_wdata=WriteDataMem`.
    - `memop` with `dmem_ready` in the same cycle: complete, stay in IDLE, `StallMem=0`.
    - `memop` without `dmem_ready`: `StallMem=1`, go to WAIT, load the timeout counter with 1.
  - WAIT:
    - `dmem_req=1` with the same address, data and write enable. These are driven from the held inputs; upstream keeps them stable under stall.
    - `StallMem=1` until the completing cycle.
    - `dmem_ready`: `StallMem=0`, capture into WB, go to IDLE.
    - Counter reaches `TIMEOUT_CYCLES` without `dmem_ready`: abort. `dmem_req` drops next cycle, `StallMem=0` in the abort cycle, WB captures a bubble, `MemErr` pulses, go to IDLE.
- WB capture:
  - `ResultW` = `dmem_rdata` if `ResultSrcMem`, else `ALU_ResultMem`.
  - `RegWrtW` = `RegWrtMem`; `RD_W` and `PCplus4W` are copied from their inputs.
  - A store captures `RegWrtW=0`, whatever `RegWrtMem` says.
- Bubble: `RegWrtW=0` while other WB fields hold their previous value. Captured on every stalled cycle, so an instruction is written back exactly once.
- `dmem_ready` arriving while `dmem_req=0` is ignored.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `RegWrtW=0`, `RD_W=0`, `ResultW=0`, `PCplus4W=0`, `MemErr=0`.
  - Combinational outputs `dmem_req`, `dmem_we`, `StallMem` are forced to 0 while `rst=0`.
- Latency to WB:
  - Non-memory op: 1 cycle.
  - Zero-wait access: 1 cycle.
  - Access with ready on the N-th request cycle: N cycles, with `StallMem` high for N-1 cycles.
- Timeout: `dmem_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `MemErr` is high for 1 cycle.
- Reset asserted mid-WAIT: `dmem_req` drops immediately and the access is abandoned. The memory must tolerate a withdrawn request.
- Back-to-back memory ops: the next request may assert in the cycle after completion.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A `memop` with `ALU_ResultMem[1:0] != 0` issues no request and does not stall.
  - WB captures a bubble, and `MemErr` pulses the next cycle.
- Undefined: no check; the address is passed through unchanged.

## Test plan
- ALU op, `ALU_ResultMem=0x1234`, `RD_Mem=5`, `RegWrtMem=1` -> next cycle `ResultW=0x1234`, `RD_W=5`, `RegWrtW=1`, `StallMem=0` throughout.
- Load from `0x100`, `dmem_ready` high in the same cycle with `dmem_rdata=0xDEADBEEF` -> no stall; next cycle `ResultW=0xDEADBEEF`, `RegWrtW=1`.
- Store to `0x200`, data `0xCAFEF00D`, ready on the 4th request cycle:
  - `dmem_req`/`dmem_we` high for 4 cycles with a stable address and data.
  - `StallMem` high for 3 cycles.
  - `RegWrtW=0` throughout.
- Load never readied, `TIMEOUT_CYCLES=16` -> `dmem_req` high for 16 cycles, then `MemErr` pulses once and `RegWrtW` stays 0.
- Load stalled in WAIT, `rst` pulsed low -> `dmem_req` and `StallMem` drop immediately; all registered outputs read 0.
- With `MEM_ALIGN_CHECK_EN`: load from `0x102` -> `dmem_req` stays 0, `MemErr` pulses, `RegWrtW=0`. Without the macro: the request is issued to `0x102`.

Source files
------------

// File: rtl/memory_stage.sv
// Pipeline MEM stage: variable-latency load/store with timeout abort and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module memory_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrtMem,
   input  logic        MemWrtMem,
   input  logic        ResultSrcMem,
   input  logic [4:0]  RD_Mem,
   input  logic [31:0] PCplus4Mem,
   input  logic [31:0] WriteDataMem,
   input  logic [31:0] ALU_ResultMem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        StallMem,
   output logic        RegWrtW,
   output logic [4:0]  RD_W,
   output logic [31:0] ResultW,
   output logic [31:0] PCplus4W,
   output logic        MemErr
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       memop, misalign, issue;
   logic       timeout, complete, err;

   assign memop = MemWrtMem | ResultSrcMem;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = memop & (ALU_ResultMem[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign issue = memop & ~misalign;

   // The IDLE request cycle counts as the first of TIMEOUT_CYCLES.
   assign timeout = (state == S_WAIT) & ~dmem_ready & (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE: begin
            if (issue && !dmem_ready) begin
               state_n = S_WAIT;
               cnt_n   = 8'd1;
            end
         end
         S_WAIT: begin
            if (dmem_ready || timeout) begin
               state_n = S_IDLE;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

   always_comb begin
      dmem_req   = rst & issue;
      dmem_we    = rst & issue & MemWrtMem;
      dmem_addr  = issue ? ALU_ResultMem : 32'd0;
      dmem_wdata = issue ? WriteDataMem : 32'd0;
      StallMem   = rst & issue & ~dmem_ready & ~timeout;
      complete   = ((state == S_IDLE) & ~memop) | (issue & dmem_ready);
      err        = timeout | ((state == S_IDLE) & misalign);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWrtW  <= 1'b0;
         RD_W     <= 5'd0;
         ResultW  <= 32'd0;
         PCplus4W <= 32'd0;
         MemErr   <= 1'b0;
      end else begin
         MemErr <= err;
         if (complete) begin
            RegWrtW  <= RegWrtMem & ~MemWrtMem;
            RD_W     <= RD_Mem;
            ResultW  <= ResultSrcMem ? dmem_rdata : ALU_ResultMem;
            PCplus4W <= PCplus4Mem;
         end else begin
            RegWrtW <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_memory_stage;

   logic        clk;
   logic        rst;
   logic        RegWrtMem, MemWrtMem, ResultSrcMem;
   logic [4:0]  RD_Mem;
   logic [31:0] PCplus4Mem, WriteDataMem, ALU_ResultMem;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        StallMem, RegWrtW, MemErr;
   logic [4:0]  RD_W;
   logic [31:0] ResultW, PCplus4W;

   int checks = 0;
   int failures = 0;

   memory_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .RegWrtMem(RegWrtMem), .MemWrtMem(MemWrtMem),
      .ResultSrcMem(ResultSrcMem), .RD_Mem(RD_Mem),
      .PCplus4Mem(PCplus4Mem), .WriteDataMem(WriteDataMem),
      .ALU_ResultMem(ALU_ResultMem),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .StallMem(StallMem), .RegWrtW(RegWrtW), .RD_W(RD_W),
      .ResultW(ResultW), .PCplus4W(PCplus4W), .MemErr(MemErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic clear_in();
      RegWrtMem = 0; MemWrtMem = 0; ResultSrcMem = 0;
      RD_Mem = 0; PCplus4Mem = 0; WriteDataMem = 0;
      ALU_ResultMem = 0; dmem_ready = 0; dmem_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      clear_in();
      ResultSrcMem = 1; MemWrtMem = 1; ALU_ResultMem = 32'h40;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || StallMem !== 1'b0) begin
         failures++;
         $display("FAIL reset_comb req=%b we=%b stall=%b exp=000", dmem_req, dmem_we, StallMem);
      end
      checks++;
      if ({RegWrtW, RD_W, ResultW, PCplus4W, MemErr} !== 71'd0) begin
         failures++;
         $display("FAIL reset_regs rw=%b rd=%0d res=%h pc=%h err=%b exp=all0",
                  RegWrtW, RD_W, ResultW, PCplus4W, MemErr);
      end
      @(negedge clk);
      clear_in();
      rst = 1;
   endtask

   task automatic test_alu();
      @(negedge clk);
      clear_in();
      RegWrtMem = 1; ALU_ResultMem = 32'h1234; RD_Mem = 5; PCplus4Mem = 32'h44;
      #1;
      checks++;
      if (StallMem !== 1'b0 || dmem_req !== 1'b0) begin
         failures++;
         $display("FAIL alu_comb stall=%b req=%b exp=0 0", StallMem, dmem_req);
      end
      @(negedge clk);
      clear_in();
      #1;
      checks++;
      if (ResultW !== 32'h1234 || RD_W !== 5'd5 || RegWrtW !== 1'b1 || PCplus4W !== 32'h44) begin
         failures++;
         $display("FAIL alu_wb res=%h rd=%0d rw=%b pc=%h exp=1234 5 1 44",
                  ResultW, RD_W, RegWrtW, PCplus4W);
      end
      checks++;
      if (StallMem !== 1'b0) begin
         failures++;
         $display("FAIL alu_stall2 stall=%b exp=0", StallMem);
      end
   endtask

   task automatic test_load_zero_wait();
      @(negedge clk);
      clear_in();
      ResultSrcMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h100; RD_Mem = 7;
      dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || StallMem !== 1'b0) begin
         failures++;
         $display("FAIL ld0_req req=%b we=%b addr=%h stall=%b exp=1 0 100 0",
                  dmem_req, dmem_we, dmem_addr, StallMem);
      end
      @(negedge clk);
      clear_in();
      #1;
      checks++;
      if (ResultW !== 32'hDEADBEEF || RegWrtW !== 1'b1 || RD_W !== 5'd7) begin
         failures++;
         $display("FAIL ld0_wb res=%h rw=%b rd=%0d exp=deadbeef 1 7", ResultW, RegWrtW, RD_W);
      end
   endtask

   task automatic test_store_wait();
      int stalls = 0;
      int bad = 0;
      @(negedge clk);
      clear_in();
      MemWrtMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h200;
      WriteDataMem = 32'hCAFEF00D; RD_Mem = 9;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 4) dmem_ready = 1;
         #1;
         if (StallMem) stalls++;
         if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
             dmem_wdata !== 32'hCAFEF00D || RegWrtW !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL st_req bad_cycles=%0d exp=0", bad);
      end
      checks++;
      if (stalls != 3) begin
         failures++;
         $display("FAIL st_stall stall_cycles=%0d exp=3", stalls);
      end
      @(negedge clk);
      clear_in();
      #1;
      checks++;
      if (RegWrtW !== 1'b0 || RD_W !== 5'd9 || dmem_req !== 1'b0) begin
         failures++;
         $display("FAIL st_wb rw=%b rd=%0d req=%b exp=0 9 0", RegWrtW, RD_W, dmem_req);
      end
   endtask

   task automatic test_timeout();
      int reqs = 0;
      int errs = 0;
      int err_at = -1;
      int rw_bad = 0;
      bit done = 0;
      @(negedge clk);
      clear_in();
      ResultSrcMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h300; RD_Mem = 11;
      for (int c = 1; c <= 24; c++) begin
         if (c > 1) @(negedge clk);
         if (done) clear_in();
         #1;
         if (dmem_req) reqs++;
         if (MemErr) begin
            errs++;
            if (err_at < 0) err_at = c;
         end
         if (RegWrtW !== 1'b0) rw_bad++;
         if (!StallMem) done = 1;
      end
      checks++;
      if (reqs != 16) begin
         failures++;
         $display("FAIL to_req req_cycles=%0d exp=16", reqs);
      end
      checks++;
      if (errs != 1 || err_at != 17) begin
         failures++;
         $display("FAIL to_err pulses=%0d at=%0d exp=1 at 17", errs, err_at);
      end
      checks++;
      if (rw_bad != 0) begin
         failures++;
         $display("FAIL to_rw regwrt_high_cycles=%0d exp=0", rw_bad);
      end
   endtask

   task automatic test_reset_midwait();
      @(negedge clk);
      clear_in();
      ResultSrcMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h400; RD_Mem = 12;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (StallMem !== 1'b1 || dmem_req !== 1'b1) begin
         failures++;
         $display("FAIL rm_pre stall=%b req=%b exp=1 1", StallMem, dmem_req);
      end
      #1 rst = 0;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || StallMem !== 1'b0 ||
          {RegWrtW, RD_W, ResultW, PCplus4W, MemErr} !== 71'd0) begin
         failures++;
         $display("FAIL rm_post req=%b stall=%b rw=%b rd=%0d res=%h pc=%h err=%b exp=all0",
                  dmem_req, StallMem, RegWrtW, RD_W, ResultW, PCplus4W, MemErr);
      end
      @(negedge clk);
      clear_in();
      rst = 1;
      @(negedge clk);
      #1;
      checks++;
      if (StallMem !== 1'b0 || MemErr !== 1'b0) begin
         failures++;
         $display("FAIL rm_after stall=%b err=%b exp=0 0", StallMem, MemErr);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      clear_in();
      ResultSrcMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h10; RD_Mem = 3;
      PCplus4Mem = 32'h84; dmem_ready = 1; dmem_rdata = 32'h11111111;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || StallMem !== 1'b0) begin
         failures++;
         $display("FAIL b2b_a req=%b stall=%b exp=1 0", dmem_req, StallMem);
      end
      @(negedge clk);
      clear_in();
      MemWrtMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h14;
      WriteDataMem = 32'h2222; RD_Mem = 2; dmem_ready = 1;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h14 ||
          ResultW !== 32'h11111111 || RegWrtW !== 1'b1 || PCplus4W !== 32'h84) begin
         failures++;
         $display("FAIL b2b_b req=%b we=%b addr=%h res=%h rw=%b pc=%h exp=1 1 14 11111111 1 84",
                  dmem_req, dmem_we, dmem_addr, ResultW, RegWrtW, PCplus4W);
      end
      @(negedge clk);
      clear_in();
      RegWrtMem = 1; ALU_ResultMem = 32'hABC; RD_Mem = 4;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || RegWrtW !== 1'b0) begin
         failures++;
         $display("FAIL b2b_c req=%b rw=%b exp=0 0", dmem_req, RegWrtW);
      end
      @(negedge clk);
      clear_in();
      #1;
      checks++;
      if (ResultW !== 32'hABC || RD_W !== 5'd4 || RegWrtW !== 1'b1) begin
         failures++;
         $display("FAIL b2b_d res=%h rd=%0d rw=%b exp=abc 4 1", ResultW, RD_W, RegWrtW);
      end
   endtask

   task automatic test_align();
      @(negedge clk);
      clear_in();
      ResultSrcMem = 1; RegWrtMem = 1; ALU_ResultMem = 32'h102; RD_Mem = 6;
      dmem_ready = 1; dmem_rdata = 32'h55;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (dmem_req !== 1'b0 || StallMem !== 1'b0) begin
         failures++;
         $display("FAIL al_req req=%b stall=%b exp=0 0", dmem_req, StallMem);
      end
`else
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h102 || StallMem !== 1'b0) begin
         failures++;
         $display("FAIL al_req req=%b addr=%h stall=%b exp=1 102 0", dmem_req, dmem_addr, StallMem);
      end
`endif
      @(negedge clk);
      clear_in();
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (MemErr !== 1'b1 || RegWrtW !== 1'b0) begin
         failures++;
         $display("FAIL al_wb err=%b rw=%b exp=1 0", MemErr, RegWrtW);
      end
`else
      checks++;
      if (MemErr !== 1'b0 || RegWrtW !== 1'b1 || ResultW !== 32'h55) begin
         failures++;
         $display("FAIL al_wb err=%b rw=%b res=%h exp=0 1 55", MemErr, RegWrtW, ResultW);
      end
`endif
      @(negedge clk);
      #1;
      checks++;
      if (MemErr !== 1'b0) begin
         failures++;
         $display("FAIL al_err_clear err=%b exp=0", MemErr);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_zero_wait();
      test_store_wait();
      test_timeout();
      test_reset_midwait();
      test_back_to_back();
      test_align();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
